// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage drives req/addr; memory answers with ack/rdata in the same cycle.
interface inst_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the pc, requests instruction memory and hands
// {pc, instruction} pairs to IF/ID. A one-entry skid buffer absorbs a response
// that lands while decode stalls; a branch redirect squashes the in-flight
// request by discarding the next ack.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_if.master        imem,
  input  logic                stall_i,
  input  logic                branch_flag_i,
  input  logic [31:0]         branch_target_i,
  output logic [31:0]         if_pc_o,
  output logic [31:0]         if_inst_o,
  output logic                if_valid_o
);

  // BOOT: single idle cycle after reset. FETCH: request outstanding.
  // HOLD: skid buffer full, waiting for decode to accept it.
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic        kill_q,      kill_d;
  logic [31:0] skid_pc_q,   skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] if_pc_q,     if_pc_d;
  logic [31:0] if_inst_q,   if_inst_d;
  logic        if_valid_q,  if_valid_d;

  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  // Next-state: boot, branch redirect, then the per-state fetch/skid handling.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so a path that does not assign
    // a signal simply holds it instead of inferring a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;

    if (state_q == ST_BOOT) begin
      state_d = ST_FETCH;
    end else if (branch_flag_i) begin
      // Redirect wins over stall and ack. A request still waiting for its ack
      // will return stale data, so mark that one ack for discard.
      pc_d       = {branch_target_i[31:2], 2'b00};
      state_d    = ST_FETCH;
      kill_d     = (state_q == ST_FETCH) && !imem.ack;
      if_valid_d = 1'b0;
      if_inst_d  = NOP_INST;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem.ack) begin
            if (kill_q) begin
              // Stale response from before the redirect; re-request pc_q.
              kill_d = 1'b0;
              if (!stall_i) begin
                if_valid_d = 1'b0;
                if_inst_d  = NOP_INST;
              end
            end else if (stall_i) begin
              skid_pc_d   = pc_q;
              skid_inst_d = imem.rdata;
              pc_d        = pc_inc;
              state_d     = ST_HOLD;
            end else begin
              if_pc_d    = pc_q;
              if_inst_d  = imem.rdata;
              if_valid_d = 1'b1;
              pc_d       = pc_inc;
            end
          end else if (!stall_i) begin
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            if_pc_d    = skid_pc_q;
            if_inst_d  = skid_inst_q;
            if_valid_d = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      skid_pc_q   <= 32'h0000_0000;
      skid_inst_q <= NOP_INST;
      if_pc_q     <= 32'h0000_0000;
      if_inst_q   <= NOP_INST;
      if_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values,
      // independent of statement order.
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign imem.req   = (state_q == ST_FETCH);
  assign imem.addr  = pc_q;
  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;
  assign if_valid_o = if_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, an async-reset sequence, and
// randomized traffic compared against a transaction-level model.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam int          N_RAND   = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  inst_fetch_if imem_bus ();

  inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (imem_bus),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;    // before the edge
    logic [31:0] exp_addr;   // before the edge
    logic        exp_valid;  // after the edge
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic br, input logic [31:0] tg,
                     input logic ak, input logic [31:0] rd,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic evld, input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.stall = st; v.branch = br; v.target = tg; v.ack = ak; v.rdata = rd;
    v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_valid = evld; v.exp_pc = epc; v.exp_inst = einst;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; } pair_t;

  bit          m_boot;
  logic [31:0] m_pc;
  pair_t       m_skid[$];
  int          m_discard;
  logic        m_valid;
  logic [31:0] m_opc;
  logic [31:0] m_inst;

  task automatic model_reset();
    m_boot = 1'b1; m_pc = RESET_PC; m_skid.delete(); m_discard = 0;
    m_valid = 1'b0; m_opc = 32'h0; m_inst = NOP;
  endtask

  function automatic bit model_req();
    return !m_boot && (m_skid.size() == 0);
  endfunction

  task automatic model_step(input logic st, input logic br, input logic [31:0] tgt,
                            input logic ak, input logic [31:0] rd);
    bit    req;
    pair_t p;
    req = model_req();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (br) begin
      m_discard = (req && !ak) ? 1 : 0;
      m_skid.delete();
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_inst  = NOP;
    end else if (!req) begin
      if (!st) begin
        p = m_skid.pop_front();
        m_valid = 1'b1; m_opc = p.pc; m_inst = p.inst;
      end
    end else if (ak) begin
      if (m_discard > 0) begin
        m_discard--;
        if (!st) begin m_valid = 1'b0; m_inst = NOP; end
      end else if (st) begin
        m_skid.push_back('{pc: m_pc, inst: rd});
        m_pc = m_pc + 32'd4;
      end else begin
        m_valid = 1'b1; m_opc = m_pc; m_inst = rd;
        m_pc = m_pc + 32'd4;
      end
    end else if (!st) begin
      m_valid = 1'b0; m_inst = NOP;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        r_st, r_br, r_ak;
    logic [31:0] r_tg, r_rd;

    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    imem_bus.ack = 1'b0; imem_bus.rdata = 32'h0;

    //   st br target        ack rdata          req addr          vld pc            inst
    add(0, 0, 32'h0,        1, 32'h100,        0, 32'h0,         0, 32'h0,         NOP);          // BOOT
    add(0, 0, 32'h0,        1, 32'h100,        1, 32'h0,         1, 32'h0,         32'h100);      // edge 2
    add(0, 0, 32'h0,        1, 32'h104,        1, 32'h4,         1, 32'h4,         32'h104);
    add(1, 0, 32'h0,        1, 32'h108,        1, 32'h8,         1, 32'h4,         32'h104);      // into skid
    add(1, 0, 32'h0,        0, 32'h0,          0, 32'hC,         1, 32'h4,         32'h104);      // HOLD
    add(1, 0, 32'h0,        0, 32'h0,          0, 32'hC,         1, 32'h4,         32'h104);
    add(0, 0, 32'h0,        0, 32'h0,          0, 32'hC,         1, 32'h8,         32'h108);      // skid out
    add(0, 0, 32'h0,        1, 32'h10C,        1, 32'hC,         1, 32'hC,         32'h10C);
    add(0, 1, 32'h203,      0, 32'h0,          1, 32'h10,        0, 32'hC,         NOP);          // branch, kill
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'h200,       0, 32'hC,         NOP);
    add(0, 0, 32'h0,        1, 32'h110,        1, 32'h200,       0, 32'hC,         NOP);          // discarded
    add(0, 0, 32'h0,        1, 32'h300,        1, 32'h200,       1, 32'h200,       32'h300);
    add(0, 0, 32'h0,        1, 32'h304,        1, 32'h204,       1, 32'h204,       32'h304);
    add(1, 0, 32'h0,        1, 32'h308,        1, 32'h208,       1, 32'h204,       32'h304);      // into skid
    add(1, 1, 32'h400,      0, 32'h0,          0, 32'h20C,       0, 32'h204,       NOP);          // branch in HOLD
    add(0, 0, 32'h0,        1, 32'h500,        1, 32'h400,       1, 32'h400,       32'h500);
    add(0, 1, 32'hFFFF_FFFC,1, 32'h504,        1, 32'h404,       0, 32'h400,       NOP);          // branch + ack
    add(0, 0, 32'h0,        1, 32'hAAAA_0001,  1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hAAAA_0001);
    add(0, 0, 32'h0,        1, 32'hAAAA_0002,  1, 32'h0,         1, 32'h0,         32'hAAAA_0002); // wrap
    add(1, 0, 32'h0,        0, 32'h0,          1, 32'h4,         1, 32'h0,         32'hAAAA_0002);
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'h4,         0, 32'h0,         NOP);
    add(0, 1, 32'h80,       0, 32'h0,          1, 32'h4,         0, 32'h0,         NOP);
    add(1, 0, 32'h0,        1, 32'hDEAD,       1, 32'h80,        0, 32'h0,         NOP);
    add(0, 0, 32'h0,        1, 32'h1080,       1, 32'h80,        1, 32'h80,        32'h1080);

    // Reset state.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.req",   {31'h0, imem_bus.req}, 32'h0);
    check("rst.addr",  imem_bus.addr, RESET_PC);
    check("rst.valid", {31'h0, if_valid_o}, 32'h0);
    check("rst.pc",    if_pc_o, 32'h0);
    check("rst.inst",  if_inst_o, NOP);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("v%0d.req", i),  {31'h0, imem_bus.req}, {31'h0, tbl[i].exp_req});
      check($sformatf("v%0d.addr", i), imem_bus.addr, tbl[i].exp_addr);
      stall_i = tbl[i].stall; branch_flag_i = tbl[i].branch; branch_target_i = tbl[i].target;
      imem_bus.ack = tbl[i].ack; imem_bus.rdata = tbl[i].rdata;
      @(negedge clk);
      check($sformatf("v%0d.valid", i), {31'h0, if_valid_o}, {31'h0, tbl[i].exp_valid});
      check($sformatf("v%0d.pc", i),    if_pc_o, tbl[i].exp_pc);
      check($sformatf("v%0d.inst", i),  if_inst_o, tbl[i].exp_inst);
    end

    // Async reset mid-cycle while a killed request is outstanding.
    stall_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h1234;
    imem_bus.ack = 1'b0;
    @(posedge clk);
    #1;
    branch_flag_i = 1'b0;
    check("kill.addr", imem_bus.addr, 32'h1234);
    #1;
    rst = 1'b0;
    #1;
    check("arst.req",   {31'h0, imem_bus.req}, 32'h0);
    check("arst.addr",  imem_bus.addr, RESET_PC);
    check("arst.valid", {31'h0, if_valid_o}, 32'h0);
    check("arst.pc",    if_pc_o, 32'h0);
    check("arst.inst",  if_inst_o, NOP);
    @(negedge clk);
    rst = 1'b1; imem_bus.ack = 1'b1; imem_bus.rdata = 32'h7777;
    @(negedge clk);
    check("arst.first_req",  {31'h0, imem_bus.req}, 32'h1);
    check("arst.first_addr", imem_bus.addr, RESET_PC);
    @(negedge clk);
    check("arst.first_valid", {31'h0, if_valid_o}, 32'h1);
    check("arst.first_pc",    if_pc_o, RESET_PC);
    check("arst.first_inst",  if_inst_o, 32'h7777);

    // Randomized traffic against the model.
    rst = 1'b0; imem_bus.ack = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < N_RAND; c++) begin
      check($sformatf("rnd%0d.req", c),  {31'h0, imem_bus.req}, {31'h0, model_req()});
      check($sformatf("rnd%0d.addr", c), imem_bus.addr, m_pc);
      r_st = ($urandom_range(0, 3) == 0);
      r_br = ($urandom_range(0, 9) == 0);
      r_ak = ($urandom_range(0, 9) < 7);
      r_rd = $urandom;
      r_tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      stall_i = r_st; branch_flag_i = r_br; branch_target_i = r_tg;
      imem_bus.ack = r_ak; imem_bus.rdata = r_rd;
      model_step(r_st, r_br, r_tg, r_ak, r_rd);
      @(negedge clk);
      check($sformatf("rnd%0d.valid", c), {31'h0, if_valid_o}, {31'h0, m_valid});
      check($sformatf("rnd%0d.pc", c),    if_pc_o, m_opc);
      check($sformatf("rnd%0d.inst", c),  if_inst_o, m_inst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage: owns the program counter, issues requests to instruction memory and delivers {pc, instruction} pairs to the IF/ID pipeline register every cycle.
- Supports back-pressure from decode through a one-entry skid buffer, and branch redirects from decode through a squash of the in-flight request.
- Sits directly upstream of if_id; its outputs feed if_id_pc_i and if_id_inst_i.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, instruction word driven during bubbles.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_i  in  1  decode stall: hold all if_* outputs.
- branch_flag_i  in  1  one-cycle redirect request from decode.
- branch_target_i  in  32  redirect address; bits [1:0] ignored, forced to 0.
- imem_req_o  out  1  instruction-memory request valid.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_ack_i  in  1  memory response; data valid in the same cycle.
- imem_rdata_i  in  32  instruction word.
- if_pc_o  out  32  pc of delivered instruction.
- if_inst_o  out  32  delivered instruction, or NOP_INST on a bubble.
- if_valid_o  out  1  if_pc_o/if_inst_o carry a real instruction.

Behaviour:
- Reset, asynchronous and active-low; rst=0 forces:
  - state=BOOT, pc_q=RESET_PC, kill_q=0, skid buffer empty.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - if_pc_o=0, if_inst_o=NOP_INST, if_valid_o=0.
  - Reset mid-request drops the request and any skid contents.
- imem_addr_o=pc_q in every state. imem_req_o=1 only in FETCH.
- pc_q increments by 4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- State BOOT: exactly one cycle after reset release, then FETCH. Outputs are a bubble.
- State FETCH: request held high with a stable address until ack.
  - ack=1, kill_q=0, no branch, stall_i=0: if_pc_o<=pc_q, if_inst_o<=rdata, if_valid_o<=1, pc_q<=pc_q+4, stay in FETCH.
  - ack=1, kill_q=0, no branch, stall_i=1: load skid buffer with {pc_q, rdata}, pc_q<=pc_q+4, go to HOLD. if_* outputs hold.
  - ack=1, kill_q=1: discard rdata, kill_q<=0. Outputs become a bubble unless stall_i=1. Request for pc_q continues next cycle.
  - ack=0, stall_i=0: outputs become a bubble (if_valid_o=0, if_inst_o=NOP_INST, if_pc_o holds). With stall_i=1, outputs hold.
- State HOLD: imem_req_o=0, if_* outputs hold while stall_i=1.
  - When stall_i=0: outputs<=skid buffer, if_valid_o<=1, buffer emptied, go to FETCH.
- Branch: branch_flag_i=1 in any non-BOOT state.
  - pc_q<={branch_target_i[31:2],2'b00}.
  - Skid buffer is dropped, state<=FETCH, outputs<=bubble.
  - If a request is outstanding and ack=0 in that cycle, set kill_q<=1; the next ack is discarded, then the target is requested.
  - If ack=1 in the same cycle, the data is discarded and kill_q stays 0.
  - Branch has priority over stall_i and over ack.
- Delay slot: the delay-slot instruction has already been delivered when decode asserts branch. Only the instruction after it is squashed.
- Latency: with ack tied high, the first valid output appears at the 2nd rising edge after reset release. Throughput is one instruction per cycle.
- imem_addr_o must not change while imem_req_o=1 and ack=0, except on a branch.

Test Plan:
- Reset release, ack tied 1, rdata=addr+32'h100: if_valid_o first high at edge 2 with pc=0, inst=32'h100. Then pc 4, 8, 12 on consecutive cycles.
- stall_i=1 for 3 cycles while an ack returns pc=8: outputs frozen at pc=4; imem_req_o=0 during HOLD; after release pc=8, then pc=12 is requested.
- Branch to 32'h0000_0203 with ack=0 outstanding for pc=16: ack arriving 2 cycles later is discarded. Next fetch address is 32'h200, delivered with if_valid_o=1; no instruction from pc=16 appears.
- Branch and stall_i asserted together in HOLD: skid entry dropped, bubble on outputs, next delivered pc equals the target.
- Wrap: branch to 32'hFFFF_FFFC, ack tied 1: delivered pcs are FFFF_FFFC, then 0000_0000.
- Assert rst=0 asynchronously mid-cycle during FETCH with kill_q=1: all outputs reset immediately. After release, the first fetch is RESET_PC with no discarded ack.
